shared_divider: RTL and testbench

Sequential restoring divider shared by the bike-computer measurement blocks (speed, average speed). It is the responder end of the divider bus: a client places the dividend and divisor on dividerbus and raises take/start on dividercontrol. The divider computes one quotient bit per clock, reports Busy/Ready and holds the quotient on dividerres until the next division.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/shared_divider.sv | 146 ++++++++++++++
 tb/tb_shared_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the bike-computer divider: FSM states, the
// dividercontrol bit map and the default operand width.
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 16;

    // dividercontrol bit positions
    localparam int unsigned DC_READY = 0;
    localparam int unsigned DC_BUSY  = 1;
    localparam int unsigned DC_TAKE  = 2;
    localparam int unsigned DC_START = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ROUND = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor when it fits, and
// report the resulting quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);

    logic [WIDTH+1:0] shifted;

    // compare-and-subtract on the shifted remainder
    always_comb begin
        shifted = {rem_i, bit_i};
        qbit_o  = (shifted >= {2'b00, divisor_i});
        if (qbit_o) begin
            rem_o = (WIDTH+1)'(shifted - {2'b00, divisor_i});
        end else begin
            rem_o = shifted[WIDTH:0];
        end
    end

endmodule

// File: rtl/shared_divider.sv
// Sequential restoring divider shared by the measurement blocks. A client
// places {dividend, divisor} on dividerbus and raises take and start; one
// quotient bit is produced per clock and the quotient is held on dividerres.
// Optional macro DIV_ROUND_EN adds a rounding cycle after the last step.
module shared_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] dividerbus,
    output logic [WIDTH-1:0]   dividerres,
    inout  wire  [3:0]         dividercontrol
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             armed_q, armed_d;

    logic             take;
    logic             start;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] q_step;

    // only a clean 1 counts; z or x from an idle client reads as 0
    assign take  = (dividercontrol[DC_TAKE]  === 1'b1);
    assign start = (dividercontrol[DC_START] === 1'b1);

    assign dividercontrol[DC_READY] = ready_q;
    assign dividercontrol[DC_BUSY]  = busy_q;
    assign dividercontrol[DC_TAKE]  = 1'bz;
    assign dividercontrol[DC_START] = 1'bz;

    assign dividerres = res_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (q_q[WIDTH-1]),
        .divisor_i (div_q),
        .rem_o     (step_rem),
        .qbit_o    (step_bit)
    );

    assign q_step = {q_q[WIDTH-2:0], step_bit};

`ifdef DIV_ROUND_EN
    logic             round_up;
    logic [WIDTH-1:0] q_round;

    // round half up; a divide by zero already holds all ones and saturates
    assign round_up = ({rem_q, 1'b0} >= {2'b00, div_q});
    assign q_round  = (&q_q) ? q_q : (q_q + 1'b1);
`endif

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            armed_q <= armed_d;
        end
    end

    // next-state: accept in IDLE, one restoring step per RUN cycle
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        div_d   = div_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        armed_d = armed_q;

        case (state_q)
            IDLE: begin
                if (armed_q && take && start) begin
                    q_d     = dividerbus[2*WIDTH-1:WIDTH];
                    div_d   = dividerbus[WIDTH-1:0];
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    armed_d = 1'b0;
                    state_d = RUN;
                end else if (!start) begin
                    armed_d = 1'b1;
                end
            end
            RUN: begin
                rem_d = step_rem;
                q_d   = q_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef DIV_ROUND_EN
                    state_d = ROUND;
`else
                    res_d   = q_step;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef DIV_ROUND_EN
            ROUND: begin
                res_d   = round_up ? q_round : q_q;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shared_divider.sv
// Randomised scoreboard bench for shared_divider: stimulus pushes the
// arithmetic quotient, a monitor pops and compares on each completion.
module tb_shared_divider;

    localparam int unsigned W = 16;
`ifdef DIV_ROUND_EN
    localparam int unsigned LAT = W + 1;
`else
    localparam int unsigned LAT = W;
`endif

    logic           clk;
    logic           rst_n;
    logic [2*W-1:0] bus;
    logic [W-1:0]   res;
    wire  [3:0]     dc;

    logic take_en, take_v, start_en, start_v;

    assign dc[2] = take_en  ? take_v  : 1'bz;
    assign dc[3] = start_en ? start_v : 1'bz;

    shared_divider #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dividerbus     (bus),
        .dividerres     (res),
        .dividercontrol (dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int completions = 0;
    int exp_done = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // quotient from plain integer arithmetic
    function automatic logic [W-1:0] ref_div(input int unsigned a, input int unsigned d);
        int unsigned q;
        int unsigned r;
        if (d == 0) return '1;
        q = a / d;
        r = a % d;
`ifdef DIV_ROUND_EN
        if (2 * r >= d) q = q + 1;
        if (q > 65535) q = 65535;
`endif
        return q[W-1:0];
    endfunction

    // monitor: one pop per busy->idle transition
    initial begin : monitor
        int busy_cnt;
        logic prev_busy;
        logic [W-1:0] e;
        busy_cnt = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                prev_busy = 1'b0;
            end else begin
                check("ready_not_busy", dc[0], !dc[1]);
                if (dc[1]) begin
                    busy_cnt++;
                end else if (prev_busy) begin
                    completions++;
                    check("latency", busy_cnt, LAT);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0d expected none", res);
                    end else begin
                        e = exp_q.pop_front();
                        check("quotient", res, e);
                    end
                    busy_cnt = 0;
                end
                prev_busy = dc[1];
            end
        end
    end

    task automatic ctl(input logic v);
        take_en = 1'b1; take_v = v;
        start_en = 1'b1; start_v = v;
    endtask

    // one idle cycle with start low (arms), then request for one edge
    task automatic issue(input int unsigned a, input int unsigned d);
        @(negedge clk);
        ctl(1'b0);
        @(negedge clk);
        bus = {a[W-1:0], d[W-1:0]};
        ctl(1'b1);
        exp_q.push_back(ref_div(a, d));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dc[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_done: got busy after %0d cycles expected idle", n);
        end
        @(negedge clk);
    endtask

    task automatic run_div(input int unsigned a, input int unsigned d);
        issue(a, d);
        ctl(1'b0);
        exp_done++;
        wait_done();
        check("completions", completions, exp_done);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned a, d, sel;
        rst_n = 1'b0;
        bus = '0;
        take_en = 1'b0; take_v = 1'b0;
        start_en = 1'b0; start_v = 1'b0;
        #22;
        check("rst_ready", dc[0], 1);
        check("rst_busy", dc[1], 0);
        check("rst_res", res, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // floating take/start must not start a division
        bus = {16'd18874, 16'd512};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_z_busy", dc[1], 0);
        end
        check("idle_z_none", completions, 0);

        // basic division
        run_div(18874, 512);

        // start held high: exactly one division
        issue(18874, 512);
        exp_done++;
        repeat (40) @(negedge clk);
        check("held_one_div", completions, exp_done);
        check("held_busy", dc[1], 0);
        check("res_hold", res, ref_div(18874, 512));
        ctl(1'b0);
        run_div(100, 7);

        // boundaries
        run_div(3, 9);
        run_div(500, 0);

        // asynchronous reset at the 5th RUN cycle
        issue(18874, 512);
        ctl(1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", dc[1], 0);
        check("midrst_ready", dc[0], 1);
        check("midrst_res", res, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_div(1000, 10);

        // operand change and stray start during RUN
        issue(18874, 512);
        ctl(1'b0);
        exp_done++;
        repeat (2) @(negedge clk);
        bus = $urandom();
        repeat (3) @(negedge clk);
        ctl(1'b1);
        @(negedge clk);
        ctl(1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        check("run_change_count", completions, exp_done);
        check("run_change_idle", dc[1], 0);

        // random operands
        for (int i = 0; i < 24; i++) begin
            a = $urandom_range(0, 65535);
            sel = $urandom_range(0, 7);
            if (sel == 0) d = 0;
            else if (sel < 4) d = $urandom_range(1, 255);
            else d = $urandom_range(1, 65535);
            run_div(a, d);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
